// File: rtl/csd_decoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : csd_decoder_pkg
//  Description : Shared CSD digit codes and the decode/convert state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package csd_decoder_pkg;

    // One digit per memory word: zero, plus one, minus one
    localparam logic [7:0] CSD_ZERO = 8'h00;
    localparam logic [7:0] CSD_POS  = 8'h01;
    localparam logic [7:0] CSD_NEG  = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_ACC  = 2'd2,
        ST_DONE = 2'd3
    } csd_state_t;

endpackage
`default_nettype wire

// File: rtl/csd_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : csd_decoder_if
//  Description : Control handshake, result bus and digit-memory port of the
//                CSD decoder.
//  Revision    : 1.0  initial release
// ============================================================================
interface csd_decoder_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int OUT_W  = 17
);
    logic                     start;
    logic [ADDR_W-1:0]        memAddr;
    logic                     memRe;
    logic [DATA_W-1:0]        memData;
    logic                     busy;
    logic                     done;
    logic signed [OUT_W-1:0]  result;
    logic                     errCode;
    logic                     errAdj;

    // Decoder side: masters the memory port and drives the result
    modport master (
        input  start, memData,
        output memAddr, memRe, busy, done, result, errCode, errAdj
    );

    // Environment side: memory plus the controller that launches decodes
    modport slave (
        output start, memData,
        input  memAddr, memRe, busy, done, result, errCode, errAdj
    );
endinterface
`default_nettype wire

// File: rtl/csd_decoder_digit_check.sv
`default_nettype none
// ============================================================================
//  Module      : csd_decoder_digit_check
//  Description : Classifies one memory word as +1, -1, 0 or an illegal code.
//  Revision    : 1.0  initial release
// ============================================================================
module csd_decoder_digit_check
    import csd_decoder_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  wire logic [DATA_W-1:0] data,
    output logic                   is_pos,
    output logic                   is_neg,
    output logic                   is_bad
);

    // Pure decode of the three legal codes; anything else is flagged bad
    always_comb begin
        is_pos = (data == DATA_W'(CSD_POS));
        is_neg = (data == DATA_W'(CSD_NEG));
        is_bad = !is_pos && !is_neg && (data != DATA_W'(CSD_ZERO));
    end

endmodule
`default_nettype wire

// File: rtl/csd_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : csd_decoder
//  Description : Reads N_DIGITS CSD digits LSB-first from the digit memory,
//                validates them and rebuilds the signed binary value.
//  Revision    : 1.0  initial release
// ============================================================================
module csd_decoder
    import csd_decoder_pkg::*;
#(
    parameter int N_DIGITS = 16,
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 8,
    parameter int OUT_W    = 17
) (
    input  wire logic     clk,
    input  wire logic     reset,
    csd_decoder_if.master bus
);

    csd_state_t          r_state;
    logic [ADDR_W-1:0]   r_idx;
    logic [OUT_W-1:0]    r_acc;
    logic                r_prev_nz;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic                r_mem_re;
    logic                r_busy;
    logic                r_done;
    logic [OUT_W-1:0]    r_result;
    logic                r_err_code;
    logic                r_err_adj;

    logic                w_is_pos;
    logic                w_is_neg;
    logic                w_is_bad;
    logic                w_nz;
    logic                w_last;
    logic [OUT_W-1:0]    w_weight;
    logic [OUT_W-1:0]    w_acc_next;

    csd_decoder_digit_check #(
        .DATA_W (DATA_W)
    ) u_digit_check (
        .data   (bus.memData),
        .is_pos (w_is_pos),
        .is_neg (w_is_neg),
        .is_bad (w_is_bad)
    );

    // Weight 2^i and the accumulator after folding in the digit now on memData
    always_comb begin
        w_nz       = w_is_pos || w_is_neg;
        w_last     = (r_idx == ADDR_W'(N_DIGITS - 1));
        w_weight   = OUT_W'(1) << r_idx;
        w_acc_next = r_acc;
        if (w_is_pos) begin
            w_acc_next = r_acc + w_weight;
        end else if (w_is_neg) begin
            w_acc_next = r_acc - w_weight;
        end
    end

    // Decode FSM: one RD cycle issues the read, the following ACC cycle consumes it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_acc      <= '0;
            r_prev_nz  <= 1'b0;
            r_mem_addr <= '0;
            r_mem_re   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_result   <= '0;
            r_err_code <= 1'b0;
            r_err_adj  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_state    <= ST_RD;
                        r_idx      <= '0;
                        r_acc      <= '0;
                        r_prev_nz  <= 1'b0;
                        r_err_code <= 1'b0;
                        r_err_adj  <= 1'b0;
                        r_mem_addr <= '0;
                        r_mem_re   <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                ST_RD: begin
                    r_mem_re <= 1'b0;
                    r_state  <= ST_ACC;
                end
                ST_ACC: begin
                    r_acc     <= w_acc_next;
                    r_prev_nz <= w_nz;
                    if (w_is_bad) begin
                        r_err_code <= 1'b1;
                    end
                    if (w_nz && r_prev_nz) begin
                        r_err_adj <= 1'b1;
                    end
                    if (w_last) begin
                        // Counter parks on the last digit; result is published with done
                        r_state  <= ST_DONE;
                        r_result <= w_acc_next;
                        r_done   <= 1'b1;
                    end else begin
                        r_idx      <= r_idx + ADDR_W'(1);
                        r_mem_addr <= r_idx + ADDR_W'(1);
                        r_mem_re   <= 1'b1;
                        r_state    <= ST_RD;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.memAddr = r_mem_addr;
    assign bus.memRe   = r_mem_re;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.result  = r_result;
    assign bus.errCode = r_err_code;
    assign bus.errAdj  = r_err_adj;

endmodule
`default_nettype wire

// File: tb/tb_csd_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_csd_decoder
//  Description : Scoreboard bench for csd_decoder with a digit-memory model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_csd_decoder;

    localparam int N_DIGITS = 16;
    localparam int ADDR_W   = 4;
    localparam int DATA_W   = 8;
    localparam int OUT_W    = 17;
    localparam int LAT      = 2 * N_DIGITS;

    typedef struct {
        longint val;
        bit     ec;
        bit     ea;
        int     start_edge;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];
    logic [7:0] mem [N_DIGITS];

    csd_decoder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .OUT_W(OUT_W)) bus ();

    csd_decoder #(
        .N_DIGITS (N_DIGITS),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .OUT_W    (OUT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    // Edge counter: at a negedge, cyc equals the number of rising edges so far
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read digit memory: data appears the cycle after memRe
    always @(posedge clk) begin
        if (bus.memRe) bus.memData <= mem[bus.memAddr];
    end

    task automatic check(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: value = sum of digit * 2^i; flags from code legality and neighbour pairs
    function automatic exp_t model(input int s_edge);
        exp_t e;
        int   dig [N_DIGITS];
        e.val = 0;
        e.ec  = 1'b0;
        e.ea  = 1'b0;
        e.start_edge = s_edge;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (mem[i] == 8'h01)      dig[i] = 1;
            else if (mem[i] == 8'hFF) dig[i] = -1;
            else begin
                dig[i] = 0;
                if (mem[i] != 8'h00) e.ec = 1'b1;
            end
            e.val += longint'(dig[i]) * (longint'(1) << i);
        end
        for (int i = 1; i < N_DIGITS; i++) begin
            if (dig[i] != 0 && dig[i-1] != 0) e.ea = 1'b1;
        end
        return e;
    endfunction

    // Monitor: pops the scoreboard whenever done is presented
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.memRe) check("addr_bound", longint'(bus.memAddr < N_DIGITS), 1);
            if (bus.done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("result", longint'($signed(bus.result)), e.val);
                    check("errCode", longint'(bus.errCode), longint'(e.ec));
                    check("errAdj", longint'(bus.errAdj), longint'(e.ea));
                    check("latency", longint'(cyc - e.start_edge), LAT);
                    check("busy_at_done", longint'(bus.busy), 1);
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_memAddr"}, longint'(bus.memAddr), 0);
        check({tag, "_memRe"},   longint'(bus.memRe), 0);
        check({tag, "_busy"},    longint'(bus.busy), 0);
        check({tag, "_done"},    longint'(bus.done), 0);
        check({tag, "_result"},  longint'(bus.result), 0);
        check({tag, "_errCode"}, longint'(bus.errCode), 0);
        check({tag, "_errAdj"},  longint'(bus.errAdj), 0);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (bus.busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (bus.busy) check("idle_timeout", 1, 0);
    endtask

    task automatic wait_drain();
        int k = 0;
        while (sb.size() != 0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            check("done_timeout", longint'(sb.size()), 0);
            sb.delete();
        end
    endtask

    task automatic run_decode();
        wait_idle();
        sb.push_back(model(cyc + 1));
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_drain();
    endtask

    task automatic clear_mem();
        for (int i = 0; i < N_DIGITS; i++) mem[i] = 8'h00;
    endtask

    task automatic random_mem();
        for (int i = 0; i < N_DIGITS; i++) begin
            case ($urandom_range(0, 9))
                6, 7:    mem[i] = 8'h01;
                8:       mem[i] = 8'hFF;
                9:       mem[i] = 8'($urandom);
                default: mem[i] = 8'h00;
            endcase
        end
    endtask

    initial begin
        int s;
        reset     = 1'b1;
        bus.start = 1'b0;
        clear_mem();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // All zero digits
        run_decode();
        // 8 - 1 = 7
        clear_mem(); mem[0] = 8'hFF; mem[3] = 8'h01;
        run_decode();
        // Most negative single digit
        clear_mem(); mem[15] = 8'hFF;
        run_decode();
        // Alternating +1 on even digits
        clear_mem();
        for (int k = 0; k < 8; k++) mem[2*k] = 8'h01;
        run_decode();
        // Adjacent nonzero digits
        clear_mem(); mem[4] = 8'h01; mem[5] = 8'h01;
        run_decode();
        // Illegal code counted as zero
        clear_mem(); mem[2] = 8'h02;
        run_decode();
        // Extremes of the range
        for (int i = 0; i < N_DIGITS; i++) mem[i] = 8'h01;
        run_decode();
        for (int i = 0; i < N_DIGITS; i++) mem[i] = 8'hFF;
        run_decode();

        // Start pulsed mid-decode is ignored: exactly one done expected
        random_mem();
        wait_idle();
        sb.push_back(model(cyc + 1));
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_drain();
        repeat (40) @(negedge clk);

        // Start held high: back-to-back decodes 34 cycles apart
        random_mem();
        s = cyc + 1;
        sb.push_back(model(s));
        sb.push_back(model(s + LAT + 2));
        sb.push_back(model(s + 2 * (LAT + 2)));
        bus.start = 1'b1;
        while (cyc < s + 2 * (LAT + 2)) @(negedge clk);
        bus.start = 1'b0;
        wait_drain();
        repeat (40) @(negedge clk);

        // Reset during the ACC cycle of digit 7
        random_mem();
        wait_idle();
        s = cyc + 1;
        sb.push_back(model(s));
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        while (cyc < s + 15) @(negedge clk);
        reset = 1'b1;
        #1;
        check_reset_outputs("midreset");
        sb.delete();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        run_decode();

        // Randomised digit patterns
        for (int t = 0; t < 20; t++) begin
            random_mem();
            run_decode();
        end

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global time bound so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
